// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Control FSM for a multi-cycle MIPS datapath with one shared ALU
//             and a single memory. It steps each instruction through
//             FETCH/DECODE/EXEC/MEM/WB, issues the per-state write enables,
//             and holds the datapath selects steady for the whole instruction.
//             It also handles syscall halt/resume and keeps the cycle and
//             retired-instruction counters used for CPI measurement.
//  Ports    : clk, rst_n (async, active-low)
//             op/func       - instruction fields from the IR
//             equal         - ALU rs==rt flag, used by beq/bne in EXEC
//             syscall_halt  - $v0==10, selects halt vs display for syscall
//             go            - resume request, only looked at while halted
//             pc_write/pc_sel/ir_write/reg_write/jal_link/mem_write
//                           - datapath write enables and PC source select
//             mem_to_reg/alu_src/reg_dst/ext_op/alu_op
//                           - held datapath selects
//             sys_disp/illegal/halted      - status
//             cycle_cnt/instr_cnt          - CPI counters, wrap silently
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               equal,
    input  logic               syscall_halt,
    input  logic               go,
    output logic               pc_write,
    output logic [1:0]         pc_sel,
    output logic               ir_write,
    output logic               reg_write,
    output logic               jal_link,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               reg_dst,
    output logic [1:0]         ext_op,
    output logic [3:0]         alu_op,
    output logic               sys_disp,
    output logic               illegal,
    output logic               halted,
    output logic [COUNT_W-1:0] cycle_cnt,
    output logic [COUNT_W-1:0] instr_cnt
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_HALT   = 3'd6;

    // Instruction classes; each class has one fixed state sequence.
    localparam logic [3:0] c_CL_RALU = 4'd0;
    localparam logic [3:0] c_CL_IALU = 4'd1;
    localparam logic [3:0] c_CL_LW   = 4'd2;
    localparam logic [3:0] c_CL_SW   = 4'd3;
    localparam logic [3:0] c_CL_BEQ  = 4'd4;
    localparam logic [3:0] c_CL_BNE  = 4'd5;
    localparam logic [3:0] c_CL_J    = 4'd6;
    localparam logic [3:0] c_CL_JAL  = 4'd7;
    localparam logic [3:0] c_CL_JR   = 4'd8;
    localparam logic [3:0] c_CL_SYS  = 4'd9;
    localparam logic [3:0] c_CL_ILL  = 4'd10;

    logic [2:0]         state_q, state_d;
    logic [COUNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [COUNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic [3:0] w_cls;
    logic [3:0] w_alu_op;
    logic [1:0] w_ext_op;
    logic       w_alu_src;
    logic       w_reg_dst;
    logic       w_sel_en;
    logic       w_retire;
    logic       w_taken;

    // ------------------------------------------------------------------
    // Instruction decode. The IR does not change between DECODE and the
    // next FETCH, so these stay constant for the whole instruction.
    // ------------------------------------------------------------------
    always_comb begin
        w_cls     = c_CL_ILL;
        w_alu_op  = 4'b1101;
        w_ext_op  = 2'b00;
        w_alu_src = 1'b0;
        w_reg_dst = 1'b0;
        case (op)
            6'b000000: begin
                w_cls     = c_CL_RALU;
                w_reg_dst = 1'b1;
                case (func)
                    6'b100000, 6'b100001: w_alu_op = 4'b0101;
                    6'b100010:            w_alu_op = 4'b0110;
                    6'b100100:            w_alu_op = 4'b0111;
                    6'b100101:            w_alu_op = 4'b1000;
                    6'b100111:            w_alu_op = 4'b1010;
                    6'b101010:            w_alu_op = 4'b1011;
                    6'b101011:            w_alu_op = 4'b1100;
                    6'b000000: begin w_alu_op = 4'b0000; w_ext_op = 2'b10; w_alu_src = 1'b1; end
                    6'b000011: begin w_alu_op = 4'b0001; w_ext_op = 2'b10; w_alu_src = 1'b1; end
                    6'b000010: begin w_alu_op = 4'b0010; w_ext_op = 2'b10; w_alu_src = 1'b1; end
                    6'b001000: begin w_cls = c_CL_JR;  w_reg_dst = 1'b0; end
                    6'b001100: begin w_cls = c_CL_SYS; w_reg_dst = 1'b0; end
                    default:   begin w_cls = c_CL_ILL; w_reg_dst = 1'b0; end
                endcase
            end
            6'b001000, 6'b001001: begin w_cls = c_CL_IALU; w_alu_op = 4'b0101; w_alu_src = 1'b1; end
            6'b001100: begin w_cls = c_CL_IALU; w_alu_op = 4'b0111; w_alu_src = 1'b1; end
            6'b001101: begin w_cls = c_CL_IALU; w_alu_op = 4'b1000; w_alu_src = 1'b1; w_ext_op = 2'b01; end
            6'b001010: begin w_cls = c_CL_IALU; w_alu_op = 4'b1011; w_alu_src = 1'b1; end
            6'b100011: begin w_cls = c_CL_LW;   w_alu_op = 4'b0101; w_alu_src = 1'b1; end
            6'b101011: begin w_cls = c_CL_SW;   w_alu_op = 4'b0101; w_alu_src = 1'b1; end
            6'b000100: w_cls = c_CL_BEQ;
            6'b000101: w_cls = c_CL_BNE;
            6'b000010: w_cls = c_CL_J;
            6'b000011: w_cls = c_CL_JAL;
            default:   w_cls = c_CL_ILL;
        endcase
    end

    assign w_sel_en = (state_q == c_DECODE) || (state_q == c_EXEC) ||
                      (state_q == c_MEM)    || (state_q == c_WB);
    assign w_taken  = (w_cls == c_CL_BEQ) ? equal : !equal;

    // Last cycle of every legal instruction; the halting syscall counts too.
    assign w_retire = ((state_q == c_DECODE) &&
                       ((w_cls == c_CL_J) || (w_cls == c_CL_JAL) ||
                        (w_cls == c_CL_JR) || (w_cls == c_CL_SYS))) ||
                      ((state_q == c_EXEC) &&
                       ((w_cls == c_CL_BEQ) || (w_cls == c_CL_BNE))) ||
                      ((state_q == c_MEM) && (w_cls == c_CL_SW)) ||
                      (state_q == c_WB);

    // ------------------------------------------------------------------
    // Next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   state_d = c_FETCH;
            c_FETCH:  state_d = c_DECODE;
            c_DECODE: begin
                case (w_cls)
                    c_CL_J, c_CL_JAL, c_CL_JR, c_CL_ILL: state_d = c_FETCH;
                    c_CL_SYS: state_d = syscall_halt ? c_HALT : c_FETCH;
                    default:  state_d = c_EXEC;
                endcase
            end
            c_EXEC: begin
                if ((w_cls == c_CL_BEQ) || (w_cls == c_CL_BNE))     state_d = c_FETCH;
                else if ((w_cls == c_CL_LW) || (w_cls == c_CL_SW)) state_d = c_MEM;
                else                                                state_d = c_WB;
            end
            c_MEM:    state_d = (w_cls == c_CL_LW) ? c_WB : c_FETCH;
            c_WB:     state_d = c_FETCH;
            c_HALT:   state_d = go ? c_FETCH : c_HALT;
            default:  state_d = c_IDLE;
        endcase

        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == c_FETCH) || w_sel_en) begin
            cycle_cnt_d = cycle_cnt_q + COUNT_W'(1);
        end
        instr_cnt_d = instr_cnt_q;
        if (w_retire) begin
            instr_cnt_d = instr_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore in state, plus the held decode and the branch flag)
    // ------------------------------------------------------------------
    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = 2'd0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        jal_link   = 1'b0;
        mem_write  = 1'b0;
        sys_disp   = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        alu_op     = w_sel_en ? w_alu_op  : 4'b0000;
        ext_op     = w_sel_en ? w_ext_op  : 2'b00;
        alu_src    = w_sel_en & w_alu_src;
        reg_dst    = w_sel_en & w_reg_dst;
        mem_to_reg = w_sel_en & (w_cls == c_CL_LW);
        case (state_q)
            c_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            c_DECODE: begin
                case (w_cls)
                    c_CL_J:   begin pc_write = 1'b1; pc_sel = 2'd2; end
                    c_CL_JAL: begin pc_write = 1'b1; pc_sel = 2'd2; reg_write = 1'b1; jal_link = 1'b1; end
                    c_CL_JR:  begin pc_write = 1'b1; pc_sel = 2'd3; end
                    c_CL_SYS: sys_disp = !syscall_halt;
                    c_CL_ILL: illegal  = 1'b1;
                    default:  ;
                endcase
            end
            c_EXEC: begin
                if (((w_cls == c_CL_BEQ) || (w_cls == c_CL_BNE)) && w_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 2'd1;
                end
            end
            c_MEM:   mem_write = (w_cls == c_CL_SW);
            c_WB:    reg_write = 1'b1;
            c_HALT:  halted    = 1'b1;
            default: ;
        endcase
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl. A table of the
//             instruction subset drives a per-instruction reference that
//             lists the expected cycles and their outputs; directed cases
//             are followed by randomly chosen instructions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int COUNT_W = 4;

    // instruction kinds of the reference table
    localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_SYS = 9, K_ILL = 10;
    // phases after FETCH
    localparam int P_D = 1, P_E = 2, P_M = 3, P_W = 4;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] aop;
        logic [1:0] ext;
        logic       src;
        logic       dst;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [5:0]         op, func;
    logic               equal, syscall_halt, go;
    logic               pc_write, ir_write, reg_write, jal_link, mem_write;
    logic               mem_to_reg, alu_src, reg_dst, sys_disp, illegal, halted;
    logic [1:0]         pc_sel, ext_op;
    logic [3:0]         alu_op;
    logic [COUNT_W-1:0] cycle_cnt, instr_cnt;

    ent_t               tbl[24];
    int                 n_tbl = 0;
    logic [COUNT_W-1:0] m_cycle, m_instr;
    int                 n_vec = 0;
    int                 n_err = 0;

    multicycle_ctrl #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .equal(equal),
        .syscall_halt(syscall_halt), .go(go),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
        .reg_write(reg_write), .jal_link(jal_link), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_dst(reg_dst),
        .ext_op(ext_op), .alu_op(alu_op), .sys_disp(sys_disp),
        .illegal(illegal), .halted(halted),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic [5:0] o, input logic [5:0] f, input int k,
                       input logic [3:0] a, input logic [1:0] e, input logic s, input logic d);
        tbl[n_tbl] = '{op: o, fn: f, kind: k, aop: a, ext: e, src: s, dst: d};
        n_tbl++;
    endtask

    function automatic int find(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].op == o && (o != 6'd0 || tbl[i].fn == f)) return i;
        end
        return -1;
    endfunction

    function automatic logic [18:0] mk(input logic pcw, input logic [1:0] sel, input logic irw,
                                       input logic rw, input logic link, input logic mw,
                                       input logic m2r, input logic src, input logic dst,
                                       input logic [1:0] ext, input logic [3:0] aop,
                                       input logic sd, input logic ill, input logic hlt);
        return {pcw, sel, irw, rw, link, mw, m2r, src, dst, ext, aop, sd, ill, hlt};
    endfunction

    // Sample at the falling edge, compare, then move just past the next rising edge.
    task automatic step(input string tag, input logic [18:0] e, input logic [18:0] msk);
        logic [18:0] o;
        @(negedge clk);
        o = {pc_write, pc_sel, ir_write, reg_write, jal_link, mem_write, mem_to_reg,
             alu_src, reg_dst, ext_op, alu_op, sys_disp, illegal, halted};
        n_vec++;
        assert ((o & msk) === (e & msk)) else begin
            n_err++;
            $error("FAIL %s outputs: observed %h expected %h", tag, o & msk, e & msk);
        end
        n_vec++;
        assert (cycle_cnt === m_cycle) else begin
            n_err++;
            $error("FAIL %s cycle_cnt: observed %0d expected %0d", tag, cycle_cnt, m_cycle);
        end
        n_vec++;
        assert (instr_cnt === m_instr) else begin
            n_err++;
            $error("FAIL %s instr_cnt: observed %0d expected %0d", tag, instr_cnt, m_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) begin
            go = 1'b0;
            step("halt_idle", mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 1), '1);
        end
        go = 1'b1;
        step("halt_go", mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 1), '1);
        go = 1'b0;
    endtask

    // eqv: -1 random, else forced equal value. abort_at: phase at which
    // reset is pulsed (0 for none). halt_n: idle cycles if syscall halts.
    task automatic do_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input int eqv, input bit sh, input int abort_at, input int halt_n);
        int          ix, k, p;
        int          ph[$];
        logic [3:0]  aop;
        logic [1:0]  ext, sel;
        logic        src, dst, eq, pcw, rw, link, mw, m2r, sd, ill, taken;
        logic [18:0] msk;
        ix = find(o, f);
        if (ix < 0) begin
            k = K_ILL; aop = 4'b1101; ext = 2'b00; src = 1'b0; dst = 1'b0;
        end else begin
            k = tbl[ix].kind; aop = tbl[ix].aop; ext = tbl[ix].ext;
            src = tbl[ix].src; dst = tbl[ix].dst;
        end
        eq = (eqv < 0) ? 1'($urandom_range(0, 1)) : 1'(eqv);
        op = o; func = f; equal = eq;
        syscall_halt = (k == K_SYS) ? sh : 1'($urandom_range(0, 1));

        go = 1'($urandom_range(0, 1));
        step({tag, "_fetch"}, mk(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0), '1);
        m_cycle = m_cycle + COUNT_W'(1);

        ph.push_back(P_D);
        if (k == K_RALU || k == K_IALU) begin ph.push_back(P_E); ph.push_back(P_W); end
        if (k == K_LW)  begin ph.push_back(P_E); ph.push_back(P_M); ph.push_back(P_W); end
        if (k == K_SW)  begin ph.push_back(P_E); ph.push_back(P_M); end
        if (k == K_BEQ || k == K_BNE) ph.push_back(P_E);

        foreach (ph[i]) begin
            p = ph[i];
            go = 1'($urandom_range(0, 1));
            if (p == abort_at) begin
                rst_n = 1'b0;
                m_cycle = '0; m_instr = '0;
                step({tag, "_abort"}, 19'd0, '1);
                rst_n = 1'b1;
                step({tag, "_idle_after_abort"}, 19'd0, '1);
                return;
            end
            pcw = 0; sel = 2'd0; rw = 0; link = 0; mw = 0; m2r = 0; sd = 0; ill = 0;
            case (p)
                P_D: case (k)
                    K_J:   begin pcw = 1; sel = 2'd2; end
                    K_JAL: begin pcw = 1; sel = 2'd2; rw = 1; link = 1; end
                    K_JR:  begin pcw = 1; sel = 2'd3; end
                    K_SYS: sd = !sh;
                    K_ILL: ill = 1;
                    default: ;
                endcase
                P_E: if (k == K_BEQ || k == K_BNE) begin
                    taken = (k == K_BEQ) ? eq : !eq;
                    pcw = taken;
                    sel = taken ? 2'd1 : 2'd0;
                end
                P_M: mw = (k == K_SW);
                P_W: begin rw = 1; m2r = (k == K_LW); end
                default: ;
            endcase
            // load write-back source only judged in WB
            msk = (k == K_LW && p != P_W) ? ~19'h00800 : '1;
            step({tag, "_ph"}, mk(pcw, sel, 0, rw, link, mw, m2r, src, dst, ext, aop, sd, ill, 0), msk);
            m_cycle = m_cycle + COUNT_W'(1);
            if (i == ph.size() - 1 && k != K_ILL) m_instr = m_instr + COUNT_W'(1);
        end
        if (k == K_SYS && sh) do_halt(halt_n);
    endtask

    initial begin
        int         idx;
        logic [5:0] o, f;
        bit         sh;
        // R-type (op 0)
        add(6'h00, 6'b100000, K_RALU, 4'b0101, 2'b00, 0, 1);
        add(6'h00, 6'b100001, K_RALU, 4'b0101, 2'b00, 0, 1);
        add(6'h00, 6'b100010, K_RALU, 4'b0110, 2'b00, 0, 1);
        add(6'h00, 6'b100100, K_RALU, 4'b0111, 2'b00, 0, 1);
        add(6'h00, 6'b100101, K_RALU, 4'b1000, 2'b00, 0, 1);
        add(6'h00, 6'b100111, K_RALU, 4'b1010, 2'b00, 0, 1);
        add(6'h00, 6'b101010, K_RALU, 4'b1011, 2'b00, 0, 1);
        add(6'h00, 6'b101011, K_RALU, 4'b1100, 2'b00, 0, 1);
        add(6'h00, 6'b000000, K_RALU, 4'b0000, 2'b10, 1, 1);
        add(6'h00, 6'b000011, K_RALU, 4'b0001, 2'b10, 1, 1);
        add(6'h00, 6'b000010, K_RALU, 4'b0010, 2'b10, 1, 1);
        add(6'h00, 6'b001000, K_JR,   4'b1101, 2'b00, 0, 0);
        add(6'h00, 6'b001100, K_SYS,  4'b1101, 2'b00, 0, 0);
        // I-type and jumps
        add(6'b001000, 6'd0, K_IALU, 4'b0101, 2'b00, 1, 0);
        add(6'b001001, 6'd0, K_IALU, 4'b0101, 2'b00, 1, 0);
        add(6'b001100, 6'd0, K_IALU, 4'b0111, 2'b00, 1, 0);
        add(6'b001101, 6'd0, K_IALU, 4'b1000, 2'b01, 1, 0);
        add(6'b001010, 6'd0, K_IALU, 4'b1011, 2'b00, 1, 0);
        add(6'b100011, 6'd0, K_LW,   4'b0101, 2'b00, 1, 0);
        add(6'b101011, 6'd0, K_SW,   4'b0101, 2'b00, 1, 0);
        add(6'b000100, 6'd0, K_BEQ,  4'b1101, 2'b00, 0, 0);
        add(6'b000101, 6'd0, K_BNE,  4'b1101, 2'b00, 0, 0);
        add(6'b000010, 6'd0, K_J,    4'b1101, 2'b00, 0, 0);
        add(6'b000011, 6'd0, K_JAL,  4'b1101, 2'b00, 0, 0);

        rst_n = 1'b0; op = 6'd0; func = 6'd0; equal = 1'b0; syscall_halt = 1'b0; go = 1'b0;
        m_cycle = '0; m_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", 19'd0, '1);
        rst_n = 1'b1;
        go = 1'b1;
        step("idle", 19'd0, '1);

        // directed cases
        do_instr("lw",        6'b100011, 6'd0,      -1, 0, 0, 0);
        do_instr("beq_taken", 6'b000100, 6'd0,       1, 0, 0, 0);
        do_instr("beq_not",   6'b000100, 6'd0,       0, 0, 0, 0);
        do_instr("bne_taken", 6'b000101, 6'd0,       0, 0, 0, 0);
        do_instr("jal",       6'b000011, 6'd0,      -1, 0, 0, 0);
        do_instr("sys_halt",  6'd0,      6'b001100, -1, 1, 0, 10);
        do_instr("sys_disp",  6'd0,      6'b001100, -1, 0, 0, 0);
        do_instr("illegal",   6'b111111, 6'd0,      -1, 0, 0, 0);
        do_instr("ill_func",  6'd0,      6'b000001, -1, 0, 0, 0);
        do_instr("sll",       6'd0,      6'b000000, -1, 0, 0, 0);
        do_instr("jr",        6'd0,      6'b001000, -1, 0, 0, 0);
        do_instr("ori",       6'b001101, 6'd0,      -1, 0, 0, 0);
        do_instr("sw_abort",  6'b101011, 6'd0,      -1, 0, P_M, 0);

        // random instruction stream
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 25);
            if (idx < 24) begin
                o = tbl[idx].op;
                f = (o == 6'd0) ? tbl[idx].fn : 6'($urandom_range(0, 63));
            end else if (idx == 24) begin
                o = 6'b111111; f = 6'($urandom_range(0, 63));
            end else begin
                o = 6'd0; f = 6'b000001;
            end
            sh = ($urandom_range(0, 3) == 0);
            if (n == 40) do_instr("rnd_abort", 6'b100011, 6'd0, -1, 0, P_E, 0);
            else         do_instr("rnd", o, f, -1, sh, 0, $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
